evt_window_scheduler: RTL and testbench

- Time-shares one event-counting datapath among NUM_CH event sources.
- On start, sweeps the enabled channels in round-robin order. For each channel it clears the counter, counts events over a fixed window, and hands the result out on a valid/ready port.
- Sits between raw event strobes (buttons, sensor pulses) and a consumer such as a display driver or UART logger.

---
 rtl/evt_window_pkg.sv | 21 ++
 rtl/rr_picker.sv | 31 +++
 rtl/evt_window_scheduler.sv | 161 ++++++++++++++++
 tb/tb_evt_window_scheduler.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/evt_window_pkg.sv
// Shared types and helpers for the windowed event-count scheduler.
// Optional macro EVT_WINDOW_EDGE_EN (used by evt_window_scheduler) selects edge counting.
package evt_window_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        CLEAR,
        COUNT,
        REPORT
    } state_e;

    // Index width for a vector of n items, never narrower than one bit
    function automatic int chan_idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEFAULT_NUM_CH = 4;
    localparam int CH_IDX_W       = chan_idx_width(DEFAULT_NUM_CH);

endpackage

// File: rtl/rr_picker.sv
// Combinational rotate-priority picker: grants the first requester strictly
// after the pointer, wrapping around, so the pointer itself is served last.
module rr_picker
    import evt_window_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int IDX_W  = chan_idx_width(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req_in,
    input  logic [IDX_W-1:0]  ptr_in,
    output logic [IDX_W-1:0]  grant_out,
    output logic              any_valid_out
);

    int idx;

    // Walk offsets from farthest to nearest so the nearest requester wins
    always_comb begin
        grant_out     = '0;
        any_valid_out = 1'b0;
        idx           = 0;
        for (int i = NUM_CH; i >= 1; i--) begin
            idx = (int'(ptr_in) + i) % NUM_CH;
            if (req_in[idx]) begin
                grant_out     = idx[IDX_W-1:0];
                any_valid_out = 1'b1;
            end
        end
    end

endmodule

// File: rtl/evt_window_scheduler.sv
// Time-shares one event counter across NUM_CH sources: each enabled channel
// in turn gets a cleared counter, a WINDOW_CYCLES counting window and a
// valid/ready result handoff.
// Define EVT_WINDOW_EDGE_EN to count rising edges instead of high cycles.
module evt_window_scheduler
    import evt_window_pkg::*;
#(
    parameter int NUM_CH        = 4,
    parameter int WINDOW_CYCLES = 100,
    parameter int COUNT_WIDTH   = 16
) (
    input  logic                       clk_in,
    input  logic                       rst_n_in,
    input  logic                       start_in,
    input  logic                       abort_in,
    input  logic [NUM_CH-1:0]          chan_mask_in,
    input  logic [NUM_CH-1:0]          evt_in,
    input  logic                       result_ready_in,
    output logic                       result_valid_out,
    output logic [COUNT_WIDTH-1:0]     result_count_out,
    output logic [$clog2(NUM_CH)-1:0]  result_chan_out,
    output logic                       result_sat_out,
    output logic                       busy_out,
    output logic                       done_out
);

    localparam int IDX_W   = chan_idx_width(NUM_CH);
    localparam int TIMER_W = chan_idx_width(WINDOW_CYCLES);
    localparam logic [TIMER_W-1:0]     TIMER_LOAD = TIMER_W'(WINDOW_CYCLES - 1);
    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX  = '1;

    state_e                 state_q, state_d;
    logic [NUM_CH-1:0]      pend_q, pend_d;
    logic [IDX_W-1:0]       ptr_q, ptr_d;
    logic [IDX_W-1:0]       sel_q, sel_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic                   sat_q, sat_d;
    logic [TIMER_W-1:0]     timer_q, timer_d;
    logic                   done_q, done_d;

    logic [IDX_W-1:0]       grant;
    logic                   grantValid;
    logic                   hit;

    rr_picker #(
        .NUM_CH (NUM_CH),
        .IDX_W  (IDX_W)
    ) u_picker (
        .req_in        (pend_q),
        .ptr_in        (ptr_q),
        .grant_out     (grant),
        .any_valid_out (grantValid)
    );

`ifdef EVT_WINDOW_EDGE_EN
    logic [NUM_CH-1:0] prev_q;

    // Remember every channel's last level so a held-high input counts once
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) prev_q <= '0;
        else           prev_q <= evt_in;
    end

    assign hit = evt_in[sel_q] & ~prev_q[sel_q];
`else
    assign hit = evt_in[sel_q];
`endif

    // State register; pointer resets to the last channel so channel 0 goes first
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= IDLE;
            pend_q  <= '0;
            ptr_q   <= IDX_W'(NUM_CH - 1);
            sel_q   <= '0;
            count_q <= '0;
            sat_q   <= 1'b0;
            timer_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            count_q <= count_d;
            sat_q   <= sat_d;
            timer_q <= timer_d;
            done_q  <= done_d;
        end
    end

    // Sweep sequencing; abort overrides whatever the current state decided
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        count_d = count_q;
        sat_d   = sat_q;
        timer_d = timer_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_in && (chan_mask_in != '0)) begin
                    pend_d  = chan_mask_in;
                    state_d = SELECT;
                end
            end
            SELECT: begin
                if (grantValid) begin
                    sel_d         = grant;
                    ptr_d         = grant;
                    pend_d[grant] = 1'b0;
                    state_d       = CLEAR;
                end else begin
                    state_d = IDLE;
                end
            end
            CLEAR: begin
                count_d = '0;
                sat_d   = 1'b0;
                timer_d = TIMER_LOAD;
                state_d = COUNT;
            end
            COUNT: begin
                if (hit) begin
                    if (count_q == COUNT_MAX) sat_d = 1'b1;
                    else                      count_d = count_q + 1'b1;
                end
                if (timer_q == '0) state_d = REPORT;
                else               timer_d = timer_q - 1'b1;
            end
            REPORT: begin
                if (result_ready_in) begin
                    if (pend_q != '0) begin
                        state_d = SELECT;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (abort_in) begin
            state_d = IDLE;
            pend_d  = '0;
            done_d  = 1'b0;
        end
    end

    assign result_valid_out = (state_q == REPORT);
    assign result_count_out = count_q;
    assign result_chan_out  = sel_q;
    assign result_sat_out   = sat_q;
    assign busy_out         = (state_q != IDLE);
    assign done_out         = done_q;

endmodule

// File: tb/tb_evt_window_scheduler.sv
// Self-checking bench for evt_window_scheduler: table-driven single-channel
// windows, hand-written multi-cycle sequences and a result scoreboard.
// Expectations follow EVT_WINDOW_EDGE_EN when it is defined.
module tb_evt_window_scheduler;

`ifdef EVT_WINDOW_EDGE_EN
    localparam bit EDGE_MODE = 1'b1;
`else
    localparam bit EDGE_MODE = 1'b0;
`endif

    typedef struct {
        int chan;
        int count;
        int sat;
    } result_t;

    typedef struct {
        int       chan;
        bit       preHigh;
        bit [7:0] pattern;
        int       expLevel;
        int       expEdge;
    } vector_t;

    logic        clk = 1'b0;
    logic        rstN;
    logic        start;
    logic        abort;
    logic        ready;
    logic [3:0]  mask;
    logic [3:0]  evt;

    logic        validA, satA, busyA, doneA;
    logic [15:0] countA;
    logic [1:0]  chanA;
    logic        validB, satB, busyB, doneB;
    logic [2:0]  countB;
    logic [1:0]  chanB;

    int          checkCount = 0;
    int          failCount  = 0;
    result_t     expQ[$];
    result_t     monExp;
    vector_t     vectors[6];

    always #5 clk = ~clk;

    evt_window_scheduler #(
        .NUM_CH(4), .WINDOW_CYCLES(8), .COUNT_WIDTH(16)
    ) dutA (
        .clk_in(clk), .rst_n_in(rstN), .start_in(start), .abort_in(abort),
        .chan_mask_in(mask), .evt_in(evt), .result_ready_in(ready),
        .result_valid_out(validA), .result_count_out(countA),
        .result_chan_out(chanA), .result_sat_out(satA),
        .busy_out(busyA), .done_out(doneA)
    );

    evt_window_scheduler #(
        .NUM_CH(4), .WINDOW_CYCLES(12), .COUNT_WIDTH(3)
    ) dutB (
        .clk_in(clk), .rst_n_in(rstN), .start_in(start), .abort_in(abort),
        .chan_mask_in(mask), .evt_in(evt), .result_ready_in(ready),
        .result_valid_out(validB), .result_count_out(countB),
        .result_chan_out(chanB), .result_sat_out(satB),
        .busy_out(busyB), .done_out(doneB)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic pushExp(input int chan, input int count, input int sat);
        result_t r;
        r.chan  = chan;
        r.count = count;
        r.sat   = sat;
        expQ.push_back(r);
    endtask

    task automatic applyReset();
        rstN  = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        ready = 1'b1;
        mask  = 4'b0;
        evt   = 4'b0;
        repeat (2) @(negedge clk);
        rstN = 1'b1;
        @(negedge clk);
    endtask

    // One single-channel window; start is sampled at edge E0, valid due after E0+10
    task automatic applyStimulus(input vector_t v);
        mask  = 4'b1 << v.chan;
        start = 1'b1;
        evt   = v.preHigh ? (4'b1 << v.chan) : 4'b0;
        pushExp(v.chan, EDGE_MODE ? v.expEdge : v.expLevel, 0);
        @(negedge clk);
        start = 1'b0;
        checkOutput("busyAfterStart", busyA, 1);
        repeat (2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            evt = v.pattern[i] ? (4'b1 << v.chan) : 4'b0;
            if (i == 7) checkOutput("validNotEarly", validA, 0);
            @(negedge clk);
        end
        checkOutput("validLatency", validA, 1);
        evt = 4'b1111;
        @(negedge clk);
        checkOutput("donePulse", doneA, 1);
        checkOutput("validDropped", validA, 0);
        checkOutput("idleAfterSweep", busyA, 0);
        evt = 4'b0;
        @(negedge clk);
        checkOutput("doneOneCycle", doneA, 0);
    endtask

    // Full sweep with ready high, one pulse per window, and a start with a
    // different mask thrown in while busy that must be ignored
    task automatic runSweep(input logic [3:0] m, input int nCh);
        mask  = m;
        start = 1'b1;
        for (int t = 0; t <= 11 * nCh; t++) begin
            if (t == 1) start = 1'b0;
            if (t == 2) begin
                start = 1'b1;
                mask  = ~m;
            end
            if (t == 3) start = 1'b0;
            evt = (t >= 3 && ((t - 3) % 11) == 2) ? 4'hF : 4'h0;
            @(negedge clk);
        end
        checkOutput("sweepDone", doneA, 1);
        evt = 4'b0;
        @(negedge clk);
        checkOutput("sweepIdle", busyA, 0);
        checkOutput("sweepDoneOnce", doneA, 0);
    endtask

    // Scoreboard: compare each handshaken result against the queued expectation
    always begin
        @(negedge clk);
        #1;
        if (rstN === 1'b1 && validA === 1'b1 && ready === 1'b1) begin
            if (expQ.size() == 0) begin
                checkCount++;
                failCount++;
                $display("[TB] FAIL unexpectedResult: chan %0d count %0d with no result expected", chanA, countA);
            end else begin
                monExp = expQ.pop_front();
                checkOutput("resultChan", chanA, monExp.chan);
                checkOutput("resultCount", countA, monExp.count);
                checkOutput("resultSat", satA, monExp.sat);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        vectors[0] = '{chan: 0, preHigh: 1'b0, pattern: 8'b0001_1111, expLevel: 5, expEdge: 1};
        vectors[1] = '{chan: 1, preHigh: 1'b0, pattern: 8'b1010_1010, expLevel: 4, expEdge: 4};
        vectors[2] = '{chan: 2, preHigh: 1'b0, pattern: 8'b1111_1111, expLevel: 8, expEdge: 1};
        vectors[3] = '{chan: 3, preHigh: 1'b0, pattern: 8'b0000_0000, expLevel: 0, expEdge: 0};
        vectors[4] = '{chan: 3, preHigh: 1'b0, pattern: 8'b0110_0110, expLevel: 4, expEdge: 2};
        vectors[5] = '{chan: 0, preHigh: 1'b1, pattern: 8'b1110_1011, expLevel: 6, expEdge: 2};

        applyReset();
        checkOutput("resetValid", validA, 0);
        checkOutput("resetBusy", busyA, 0);
        checkOutput("resetDone", doneA, 0);
        checkOutput("resetCount", countA, 0);
        checkOutput("resetChan", chanA, 0);
        checkOutput("resetSat", satA, 0);
        checkOutput("resetBusyB", busyB, 0);
        checkOutput("resetValidB", validB, 0);

        mask  = 4'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("zeroMaskIgnored", busyA, 0);

        for (int k = 0; k < 6; k++) applyStimulus(vectors[k]);

        $display("[TB] round-robin sweeps");
        applyReset();
        pushExp(0, 1, 0);
        pushExp(1, 1, 0);
        pushExp(3, 1, 0);
        runSweep(4'b1011, 3);
        pushExp(0, 1, 0);
        pushExp(1, 1, 0);
        pushExp(2, 1, 0);
        pushExp(3, 1, 0);
        runSweep(4'b1111, 4);

        $display("[TB] backpressure");
        pushExp(0, 3, 0);
        pushExp(1, 2, 0);
        mask  = 4'b0011;
        start = 1'b1;
        ready = 1'b0;
        evt   = 4'b0;
        for (int t = 0; t <= 42; t++) begin
            if (t == 1) start = 1'b0;
            if (t >= 11 && t <= 30) begin
                checkOutput("bpValidHeld", validA, 1);
                checkOutput("bpCountHeld", countA, 3);
                checkOutput("bpChanHeld", chanA, 0);
            end
            if (t == 3 || t == 5 || t == 7)      evt = 4'b0001;
            else if (t >= 11 && t <= 30)         evt = t[0] ? 4'hF : 4'h0;
            else if (t == 34 || t == 36)         evt = 4'b0010;
            else                                 evt = 4'b0000;
            ready = (t >= 31);
            if (t == 32) begin
                checkOutput("bpValidDrop", validA, 0);
                checkOutput("bpStillBusy", busyA, 1);
            end
            if (t == 41) checkOutput("bpNextNotEarly", validA, 0);
            if (t == 42) checkOutput("bpNextLatency", validA, 1);
            @(negedge clk);
        end
        checkOutput("bpDone", doneA, 1);
        ready = 1'b1;
        @(negedge clk);

        $display("[TB] saturation");
        applyReset();
        pushExp(0, EDGE_MODE ? 0 : 8, 0);
        mask  = 4'b0001;
        evt   = 4'b0001;
        start = 1'b1;
        for (int t = 0; t <= 14; t++) begin
            if (t == 1) start = 1'b0;
            if (t == 14) checkOutput("satValidNotEarly", validB, 0);
            @(negedge clk);
        end
        checkOutput("satValid", validB, 1);
        checkOutput("satCount", countB, EDGE_MODE ? 0 : 7);
        checkOutput("satFlag", satB, EDGE_MODE ? 0 : 1);
        checkOutput("satChan", chanB, 0);
        evt = 4'b0;
        @(negedge clk);
        checkOutput("satDoneB", doneB, 1);
        @(negedge clk);

        $display("[TB] abort");
        applyReset();
        mask  = 4'b0001;
        start = 1'b1;
        for (int t = 0; t <= 5; t++) begin
            if (t == 1) start = 1'b0;
            if (t == 2) begin
                start = 1'b1;
                mask  = 4'b1111;
            end
            if (t == 3) begin
                start = 1'b0;
                mask  = 4'b0001;
            end
            if (t == 5) begin
                checkOutput("abortBusyBefore", busyA, 1);
                abort = 1'b1;
            end
            @(negedge clk);
        end
        abort = 1'b0;
        checkOutput("abortBusy", busyA, 0);
        checkOutput("abortValid", validA, 0);
        checkOutput("abortNoDone", doneA, 0);
        @(negedge clk);
        checkOutput("abortStaysIdle", busyA, 0);
        checkOutput("abortNoDoneLater", doneA, 0);
        pushExp(1, 1, 0);
        pushExp(0, 1, 0);
        runSweep(4'b0011, 2);

        $display("[TB] reset during report");
        mask  = 4'b0100;
        ready = 1'b0;
        start = 1'b1;
        for (int t = 0; t <= 10; t++) begin
            if (t == 1) start = 1'b0;
            evt = (t >= 3 && t <= 6) ? 4'b0100 : 4'b0000;
            @(negedge clk);
        end
        checkOutput("rstValidBefore", validA, 1);
        checkOutput("rstCountBefore", countA, EDGE_MODE ? 1 : 4);
        #2;
        rstN = 1'b0;
        #1;
        checkOutput("rstAsyncValid", validA, 0);
        checkOutput("rstAsyncBusy", busyA, 0);
        checkOutput("rstAsyncCount", countA, 0);
        checkOutput("rstAsyncChan", chanA, 0);
        @(negedge clk);
        rstN  = 1'b1;
        ready = 1'b1;
        @(negedge clk);
        pushExp(2, 1, 0);
        pushExp(3, 1, 0);
        runSweep(4'b1100, 2);

        repeat (3) @(negedge clk);
        checkOutput("scoreboardDrained", expQ.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
